// File: rtl/latency_memory_pkg.sv
// Shared constants and encodings for the latency_memory slow-memory model.
package latency_memory_pkg;
    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;
endpackage

// File: rtl/latency_memory_if.sv
// Request/acknowledge handshake between the CPU bus master and latency_memory.
interface latency_memory_if
    import latency_memory_pkg::*;
();
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 input_ready;
    logic                 ack_output;
    logic                 req_error;

    modport master (
        output readM, writeM, address,
        input  input_ready, ack_output, req_error
    );

    modport slave (
        input  readM, writeM, address,
        output input_ready, ack_output, req_error
    );
endinterface

// File: rtl/latency_memory_mem_array.sv
// Single-port synchronous RAM, read-first, registered read data, no reset.
module latency_memory_mem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/latency_memory.sv
// Slow word memory: fixed access latency, 4-phase handshake, tristated read-data return.
module latency_memory
    import latency_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    latency_memory_if.slave      bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state;
    op_t                   op;
    logic [3:0]            counter;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic [WORD_SIZE-1:0]  rdata;
    logic                  input_ready_q;
    logic                  ack_output_q;
    logic                  req_error_q;
    logic                  mem_we;
    logic                  unused_addr;

    // Upper address bits alias onto the implemented depth.
    assign unused_addr = ^bus.address[WORD_SIZE-1:ADDR_WIDTH];

    // The RAM access lands on the edge that leaves BUSY, so write commit and read capture coincide.
    assign mem_we = (state == ST_BUSY) && (counter == 4'd0) && (op == OP_WR);

    latency_memory_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WORD_SIZE)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            counter       <= 4'd0;
            input_ready_q <= 1'b0;
            ack_output_q  <= 1'b0;
            req_error_q   <= 1'b0;
        end else begin
            input_ready_q <= 1'b0;
            ack_output_q  <= 1'b0;
            req_error_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.readM && bus.writeM) begin
                        req_error_q <= 1'b1;
                    end else if (bus.readM || bus.writeM) begin
                        op      <= bus.writeM ? OP_WR : OP_RD;
                        addr_q  <= bus.address[ADDR_WIDTH-1:0];
                        wdata_q <= data;
                        counter <= CNT_INIT;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (counter == 4'd0) begin
                        state <= ST_DONE;
                        if (op == OP_WR) begin
                            ack_output_q <= 1'b1;
                        end else begin
                            input_ready_q <= 1'b1;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= (bus.readM || bus.writeM) ? ST_RELEASE : ST_IDLE;
                end
                ST_RELEASE: begin
                    if (!bus.readM && !bus.writeM) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.input_ready = input_ready_q;
    assign bus.ack_output  = ack_output_q;
    assign bus.req_error   = req_error_q;

    assign data = (state == ST_DONE && op == OP_RD) ? rdata : {WORD_SIZE{1'bz}};
endmodule
